uart_apb_sequencer: RTL and testbench

- APB3 master that owns one CoreUART APB slave and shares it between two byte-stream transmit requesters.
- Issues configuration writes after reset and on request, then polls the UART status register.
- Forwards TX bytes when TXRDY is set and drains RX bytes when RXRDY is set.
- Sits between the processor-side stream logic and the UART; software never touches the UART directly.

---
 rtl/uart_apb_sequencer.sv | 221 ++++++++++++++++++++++
 tb/tb_uart_apb_sequencer.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_apb_sequencer.sv
// uart_apb_sequencer
//   APB3 master that owns a single CoreUART slave. After reset, and again on
//   request, it writes the UART control registers. It then polls STATUS and,
//   depending on what that read returns, drains one RX byte or forwards one TX
//   byte from whichever of the two requesters wins round-robin arbitration.
//
// Ports
//   PCLK, aresetn          clock, asynchronous active-low reset
//   cfg_*                  configuration values; cfg_load requests a reconfiguration
//   cfg_done               configuration complete
//   tx{0,1}_data/valid     requester bytes; tx{0,1}_ready pulses on acceptance
//   rx_data/rx_valid       received byte, cleared by rx_ready
//   m_p*                   APB3 master interface to the UART (m_pslverr is ignored)
//   err_parity/framing/overflow  sticky UART error flags; err_clr clears them
//
// State  | meaning
// -------+-----------------------------------------------------------
// C1     | write baud low byte to CTRL1
// C2     | write baud high bits and frame format to CTRL2
// C3     | write fractional baud to CTRL3 (only when FRAC_EN=1)
// POLL   | read STATUS and choose the next operation
// RXRD   | read RXDATA into rx_data
// TXWR   | write the granted requester byte to TXDATA
//
// Every operation runs through three phases: IDLE (psel low), SETUP and
// ACCESS. IDLE is the mandatory gap after each completed transfer.

module uart_apb_sequencer #(
    parameter bit FRAC_EN = 1'b0,
    parameter bit RX_EN   = 1'b1
) (
    input  logic        PCLK,
    input  logic        aresetn,
    input  logic [12:0] cfg_baud,
    input  logic [2:0]  cfg_frac,
    input  logic        cfg_bit8,
    input  logic        cfg_parity_en,
    input  logic        cfg_odd_n_even,
    input  logic        cfg_load,
    output logic        cfg_done,
    input  logic [7:0]  tx0_data,
    input  logic        tx0_valid,
    output logic        tx0_ready,
    input  logic [7:0]  tx1_data,
    input  logic        tx1_valid,
    output logic        tx1_ready,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    input  logic        rx_ready,
    output logic [4:0]  m_paddr,
    output logic        m_psel,
    output logic        m_penable,
    output logic        m_pwrite,
    output logic [7:0]  m_pwdata,
    input  logic [7:0]  m_prdata,
    input  logic        m_pready,
    input  logic        m_pslverr,
    output logic        err_parity,
    output logic        err_framing,
    output logic        err_overflow,
    input  logic        err_clr
);

    localparam logic [4:0] ADDR_TXDATA = 5'h00;
    localparam logic [4:0] ADDR_RXDATA = 5'h04;
    localparam logic [4:0] ADDR_CTRL1  = 5'h08;
    localparam logic [4:0] ADDR_CTRL2  = 5'h0C;
    localparam logic [4:0] ADDR_STATUS = 5'h10;
    localparam logic [4:0] ADDR_CTRL3  = 5'h14;

    typedef enum logic [2:0] {
        ST_C1, ST_C2, ST_C3, ST_POLL, ST_RXRD, ST_TXWR
    } state_t;

    typedef enum logic [1:0] {
        PH_IDLE, PH_SETUP, PH_ACCESS
    } phase_t;

    state_t state;
    phase_t phase;
    logic   cfg_pend;
    logic   rr_last;     // requester that won the previous TX write
    logic   grant;       // requester owning the TX write in flight
    logic   xfer_done;
    logic   win1;
    logic   unused_inputs;

    assign xfer_done     = (phase == PH_ACCESS) && m_pready;
    // With both requesters valid, the one that did not win last time goes next.
    assign win1          = tx1_valid && (!tx0_valid || !rr_last);
    // Ready must coincide with the completion cycle, so it cannot be registered.
    assign tx0_ready     = xfer_done && (state == ST_TXWR) && !grant;
    assign tx1_ready     = xfer_done && (state == ST_TXWR) && grant;
    assign unused_inputs = m_pslverr;

    always_ff @(posedge PCLK or negedge aresetn) begin
        if (!aresetn) begin
            state        <= ST_C1;
            phase        <= PH_IDLE;
            cfg_pend     <= 1'b0;
            cfg_done     <= 1'b0;
            rr_last      <= 1'b1;
            grant        <= 1'b0;
            rx_data      <= 8'h00;
            rx_valid     <= 1'b0;
            m_paddr      <= 5'h00;
            m_psel       <= 1'b0;
            m_penable    <= 1'b0;
            m_pwrite     <= 1'b0;
            m_pwdata     <= 8'h00;
            err_parity   <= 1'b0;
            err_framing  <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            if (rx_valid && rx_ready)
                rx_valid <= 1'b0;

            case (phase)
                PH_IDLE: begin
                    m_psel <= 1'b1;
                    phase  <= PH_SETUP;
                    case (state)
                        ST_C1: begin
                            m_paddr  <= ADDR_CTRL1;
                            m_pwrite <= 1'b1;
                            m_pwdata <= cfg_baud[7:0];
                        end
                        ST_C2: begin
                            m_paddr  <= ADDR_CTRL2;
                            m_pwrite <= 1'b1;
                            m_pwdata <= {cfg_baud[12:8], cfg_odd_n_even, cfg_parity_en, cfg_bit8};
                        end
                        ST_C3: begin
                            m_paddr  <= ADDR_CTRL3;
                            m_pwrite <= 1'b1;
                            m_pwdata <= {5'b00000, cfg_frac};
                        end
                        ST_RXRD: begin
                            m_paddr  <= ADDR_RXDATA;
                            m_pwrite <= 1'b0;
                            m_pwdata <= 8'h00;
                        end
                        ST_TXWR: begin
                            m_paddr  <= ADDR_TXDATA;
                            m_pwrite <= 1'b1;
                            grant    <= win1;
                            m_pwdata <= win1 ? tx1_data : tx0_data;
                        end
                        default: begin
                            m_paddr  <= ADDR_STATUS;
                            m_pwrite <= 1'b0;
                            m_pwdata <= 8'h00;
                        end
                    endcase
                end

                PH_SETUP: begin
                    m_penable <= 1'b1;
                    phase     <= PH_ACCESS;
                end

                default: begin
                    if (m_pready) begin
                        m_psel    <= 1'b0;
                        m_penable <= 1'b0;
                        phase     <= PH_IDLE;
                        case (state)
                            ST_C1: state <= ST_C2;
                            ST_C2: begin
                                state <= FRAC_EN ? ST_C3 : ST_POLL;
                                if (!FRAC_EN)
                                    cfg_done <= 1'b1;
                            end
                            ST_C3: begin
                                state    <= ST_POLL;
                                cfg_done <= 1'b1;
                            end
                            ST_POLL: begin
                                err_parity   <= err_parity   | m_prdata[2];
                                err_overflow <= err_overflow | m_prdata[3];
                                err_framing  <= err_framing  | m_prdata[4];
                                if (cfg_pend) begin
                                    state    <= ST_C1;
                                    cfg_pend <= 1'b0;
                                end else if (RX_EN && m_prdata[1] && !rx_valid) begin
                                    state <= ST_RXRD;
                                end else if (m_prdata[0] && (tx0_valid || tx1_valid)) begin
                                    state <= ST_TXWR;
                                end
                            end
                            ST_RXRD: begin
                                rx_data  <= m_prdata;
                                rx_valid <= 1'b1;
                                state    <= ST_POLL;
                            end
                            ST_TXWR: begin
                                rr_last <= grant;
                                state   <= ST_POLL;
                            end
                            default: state <= ST_C1;
                        endcase
                    end
                end
            endcase

            // Clear beats a same-cycle set from a STATUS read.
            if (err_clr) begin
                err_parity   <= 1'b0;
                err_framing  <= 1'b0;
                err_overflow <= 1'b0;
            end

            // A new request always wins, even over a completion that would set cfg_done.
            if (cfg_load) begin
                cfg_pend <= 1'b1;
                cfg_done <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_apb_sequencer.sv
`timescale 1ns/1ps
module tb_uart_apb_sequencer;

    logic        PCLK = 1'b0;
    logic        aresetn = 1'b0;
    logic [12:0] cfg_baud = 13'h1A5;
    logic [2:0]  cfg_frac = 3'd5;
    logic        cfg_bit8 = 1'b1, cfg_parity_en = 1'b1, cfg_odd_n_even = 1'b0;
    logic        cfg_load = 1'b0;
    logic        cfg_done;
    logic [7:0]  tx0_data = 8'h00, tx1_data = 8'h00;
    logic        tx0_valid = 1'b0, tx1_valid = 1'b0;
    logic        tx0_ready, tx1_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready = 1'b0;
    logic [4:0]  m_paddr;
    logic        m_psel, m_penable, m_pwrite;
    logic [7:0]  m_pwdata;
    logic [7:0]  m_prdata;
    logic        m_pready;
    logic        m_pslverr = 1'b0;
    logic        err_parity, err_framing, err_overflow;
    logic        err_clr = 1'b0;

    uart_apb_sequencer #(.FRAC_EN(1'b1), .RX_EN(1'b1)) dut (
        .PCLK(PCLK), .aresetn(aresetn),
        .cfg_baud(cfg_baud), .cfg_frac(cfg_frac), .cfg_bit8(cfg_bit8),
        .cfg_parity_en(cfg_parity_en), .cfg_odd_n_even(cfg_odd_n_even),
        .cfg_load(cfg_load), .cfg_done(cfg_done),
        .tx0_data(tx0_data), .tx0_valid(tx0_valid), .tx0_ready(tx0_ready),
        .tx1_data(tx1_data), .tx1_valid(tx1_valid), .tx1_ready(tx1_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .m_paddr(m_paddr), .m_psel(m_psel), .m_penable(m_penable),
        .m_pwrite(m_pwrite), .m_pwdata(m_pwdata), .m_prdata(m_prdata),
        .m_pready(m_pready), .m_pslverr(m_pslverr),
        .err_parity(err_parity), .err_framing(err_framing),
        .err_overflow(err_overflow), .err_clr(err_clr)
    );

    always #5 PCLK = ~PCLK;

    // ---------------- UART slave model ----------------
    logic [7:0] status_val = 8'h00;
    logic [7:0] rxdata_val = 8'h00;
    int         wait_cycles = 0;
    int         acc_cnt = 0;

    assign m_prdata = (m_paddr == 5'h10) ? status_val :
                      (m_paddr == 5'h04) ? rxdata_val : 8'h00;
    assign m_pready = m_psel && m_penable && (acc_cnt >= wait_cycles);

    always @(posedge PCLK) begin
        if (m_psel && m_penable && !m_pready) acc_cnt <= acc_cnt + 1;
        else                                  acc_cnt <= 0;
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic       wr;
        logic [4:0] addr;
        logic [7:0] data;
    } xfer_t;

    xfer_t      exp_q[$];
    logic [4:0] log_q[$];
    int         n_cmp = 0;
    int         n_fail = 0;
    int         ready_cnt = 0;
    int         cur_len = 0;
    int         last_len = 0;
    logic       prev_done = 1'b0;
    logic [4:0] cap_addr = 5'h00;
    logic [7:0] cap_wdata = 8'h00;
    logic       cap_wr = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic wr, input logic [4:0] a, input logic [7:0] d);
        xfer_t x;
        x.wr = wr; x.addr = a; x.data = d;
        exp_q.push_back(x);
    endtask

    always @(negedge PCLK) begin
        if (aresetn) begin
            logic  done;
            xfer_t e;
            logic [7:0] obs_data;
            done = m_psel && m_penable && m_pready;
            if (prev_done) chk("idle_gap_psel", 32'(m_psel), 32'd0);
            if (m_psel && !m_penable) begin
                cap_addr  = m_paddr;
                cap_wdata = m_pwdata;
                cap_wr    = m_pwrite;
                cur_len   = 0;
            end
            if (m_psel && m_penable) begin
                cur_len++;
                chk("hold_ctrl", {m_paddr, m_pwdata, m_pwrite}, {cap_addr, cap_wdata, cap_wr});
            end
            if (tx0_ready || tx1_ready) begin
                ready_cnt++;
                chk("ready_in_completion",
                    32'(done && m_pwrite && (m_paddr == 5'h00) && (tx0_ready ^ tx1_ready)), 32'd1);
                chk("ready_data", 32'(m_pwdata), 32'(tx0_ready ? tx0_data : tx1_data));
            end
            if (done) begin
                last_len = cur_len;
                log_q.push_back(m_paddr);
                obs_data = m_pwrite ? m_pwdata : m_prdata;
                if (m_paddr != 5'h10) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL unexpected_xfer: got wr=%0b addr 0x%0h data 0x%0h, none expected (t=%0t)",
                                 m_pwrite, m_paddr, obs_data, $time);
                    end else begin
                        e = exp_q.pop_front();
                        chk("xfer", {m_pwrite, m_paddr, obs_data}, {e.wr, e.addr, e.data});
                    end
                end
            end
            prev_done = done;
        end else begin
            prev_done = 1'b0;
        end
    end

    // ---------------- helpers ----------------
    task automatic wait_cyc(input int n);
        repeat (n) @(negedge PCLK);
    endtask

    task automatic wait_ready(input int target, input int budget, input string name);
        int k;
        k = 0;
        while (ready_cnt < target && k < budget) begin
            @(negedge PCLK);
            k++;
        end
        chk(name, 32'(ready_cnt), 32'(target));
    endtask

    // kind 0: SETUP of addr a, kind 1: completion of addr a, kind 2: any ACCESS
    task automatic wait_phase(input logic [4:0] a, input int kind, input string name);
        int   k;
        logic hit;
        k = 0;
        hit = 1'b0;
        while (!hit && k < 100) begin
            @(negedge PCLK);
            k++;
            case (kind)
                0:       hit = m_psel && !m_penable && (m_paddr == a);
                1:       hit = m_psel && m_penable && m_pready && (m_paddr == a);
                default: hit = m_psel && m_penable;
            endcase
        end
        chk(name, 32'(hit), 32'd1);
    endtask

    task automatic wait_cfg_done(input string name);
        int k;
        k = 0;
        while (!cfg_done && k < 100) begin
            @(negedge PCLK);
            k++;
        end
        chk(name, 32'(cfg_done), 32'd1);
    endtask

    // ---------------- TX vector table ----------------
    typedef struct {
        logic [7:0] status;
        logic       v0;
        logic [7:0] d0;
        logic       v1;
        logic [7:0] d1;
        int         n;
        logic [7:0] e0, e1, e2;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         base;
        int         k;
        logic [7:0] ev[3];

        // Pointer starts so that requester 0 wins the first contested grant.
        vecs[0] = '{8'h01, 1'b1, 8'h55, 1'b1, 8'hAA, 3, 8'h55, 8'hAA, 8'h55};
        vecs[1] = '{8'h01, 1'b0, 8'h00, 1'b1, 8'h11, 2, 8'h11, 8'h11, 8'h00};
        vecs[2] = '{8'h01, 1'b1, 8'h22, 1'b0, 8'h00, 1, 8'h22, 8'h00, 8'h00};
        vecs[3] = '{8'h01, 1'b1, 8'h33, 1'b1, 8'h44, 2, 8'h44, 8'h33, 8'h00};
        vecs[4] = '{8'h00, 1'b1, 8'h5A, 1'b1, 8'hA5, 0, 8'h00, 8'h00, 8'h00};
        vecs[5] = '{8'h01, 1'b1, 8'h66, 1'b1, 8'h77, 1, 8'h77, 8'h00, 8'h00};

        // ---- reset state and initial configuration ----
        wait_cyc(3);
        chk("reset_outputs",
            {m_psel, m_penable, m_pwrite, m_paddr, m_pwdata, cfg_done, tx0_ready, tx1_ready,
             rx_valid, rx_data, err_parity, err_framing, err_overflow}, 32'd0);
        push(1'b1, 5'h08, 8'hA5);
        push(1'b1, 5'h0C, 8'h0B);
        push(1'b1, 5'h14, 8'h05);
        @(posedge PCLK); #1 aresetn = 1'b1;
        wait_phase(5'h14, 1, "ctrl3_completion");
        chk("cfg_done_during_ctrl3", 32'(cfg_done), 32'd0);
        @(negedge PCLK);
        chk("cfg_done_after_ctrl3", 32'(cfg_done), 32'd1);
        wait_cyc(6);
        chk("init_sequence", {log_q[0], log_q[1], log_q[2], log_q[3]},
            {5'h08, 5'h0C, 5'h14, 5'h10});
        chk("init_drained", 32'(exp_q.size()), 32'd0);

        // ---- table-driven TX arbitration ----
        for (int i = 0; i < 6; i++) begin
            status_val = vecs[i].status;
            tx0_valid  = vecs[i].v0;
            tx0_data   = vecs[i].d0;
            tx1_valid  = vecs[i].v1;
            tx1_data   = vecs[i].d1;
            base       = ready_cnt;
            ev[0] = vecs[i].e0; ev[1] = vecs[i].e1; ev[2] = vecs[i].e2;
            for (int j = 0; j < vecs[i].n; j++) push(1'b1, 5'h00, ev[j]);
            if (vecs[i].n == 0) begin
                wait_cyc(30);
                chk("no_tx_without_txrdy", 32'(ready_cnt), 32'(base));
            end else begin
                wait_ready(base + vecs[i].n, 40 * vecs[i].n, "tx_ready_count");
            end
            @(posedge PCLK); #1;
            tx0_valid = 1'b0;
            tx1_valid = 1'b0;
            wait_cyc(8);
            chk("tx_vec_drained", 32'(exp_q.size()), 32'd0);
        end

        // ---- RX read, then TX-only polls while rx_valid is held ----
        rxdata_val = 8'h3C;
        tx0_data   = 8'h5A;
        tx0_valid  = 1'b1;
        status_val = 8'h03;
        push(1'b0, 5'h04, 8'h3C);
        push(1'b1, 5'h00, 8'h5A);
        push(1'b1, 5'h00, 8'h5A);
        base = ready_cnt;
        wait_ready(base + 2, 100, "rx_then_tx_count");
        @(posedge PCLK); #1 tx0_valid = 1'b0;
        wait_cyc(15);
        chk("rx_held", {rx_valid, rx_data}, {1'b1, 8'h3C});
        chk("rx_phase_drained", 32'(exp_q.size()), 32'd0);
        rxdata_val = 8'hC3;
        push(1'b0, 5'h04, 8'hC3);
        @(posedge PCLK); #1 rx_ready = 1'b1;
        @(posedge PCLK); #1 rx_ready = 1'b0;
        chk("rx_valid_cleared", 32'(rx_valid), 32'd0);
        k = 0;
        while (!rx_valid && k < 40) begin @(negedge PCLK); k++; end
        chk("rx_second_byte", {rx_valid, rx_data}, {1'b1, 8'hC3});
        status_val = 8'h00;
        @(posedge PCLK); #1 rx_ready = 1'b1;
        @(posedge PCLK); #1 rx_ready = 1'b0;
        wait_cyc(10);
        chk("rx_second_drained", 32'(exp_q.size()), 32'd0);

        // ---- wait states on a TX write ----
        wait_cycles = 4;
        status_val  = 8'h01;
        tx0_data    = 8'h99;
        tx0_valid   = 1'b1;
        push(1'b1, 5'h00, 8'h99);
        base = ready_cnt;
        wait_ready(base + 1, 60, "wait_state_ready");
        chk("wait_state_access_len", 32'(last_len), 32'd5);
        @(posedge PCLK); #1 tx0_valid = 1'b0;
        status_val = 8'h00;
        wait_cyc(20);
        wait_cycles = 0;
        wait_cyc(10);

        // ---- sticky error flags ----
        status_val = 8'h14;
        wait_cyc(10);
        status_val = 8'h00;
        wait_cyc(10);
        chk("err_sticky", {err_parity, err_framing, err_overflow}, {1'b1, 1'b1, 1'b0});
        @(posedge PCLK); #1 err_clr = 1'b1;
        @(posedge PCLK); #1 err_clr = 1'b0;
        chk("err_cleared", {err_parity, err_framing, err_overflow}, 32'd0);
        wait_phase(5'h10, 1, "poll_for_clr_race");
        status_val = 8'h08;
        err_clr    = 1'b1;
        @(posedge PCLK); #1;
        status_val = 8'h00;
        err_clr    = 1'b0;
        wait_cyc(4);
        chk("err_clr_priority", 32'(err_overflow), 32'd0);
        status_val = 8'h08;
        wait_cyc(10);
        status_val = 8'h00;
        wait_cyc(4);
        chk("err_overflow_set", 32'(err_overflow), 32'd1);
        @(posedge PCLK); #1 err_clr = 1'b1;
        @(posedge PCLK); #1 err_clr = 1'b0;

        // ---- cfg_load during an RX read ----
        rxdata_val = 8'h81;
        status_val = 8'h02;
        wait_phase(5'h04, 0, "rxrd_setup");
        log_q.delete();
        push(1'b0, 5'h04, 8'h81);
        push(1'b1, 5'h08, 8'hA5);
        push(1'b1, 5'h0C, 8'h0B);
        push(1'b1, 5'h14, 8'h05);
        @(negedge PCLK);
        chk("cfg_done_before_load", 32'(cfg_done), 32'd1);
        cfg_load = 1'b1;
        @(posedge PCLK); #1 cfg_load = 1'b0;
        chk("cfg_done_cleared", 32'(cfg_done), 32'd0);
        wait_cfg_done("reconfig_done");
        chk("reconfig_sequence", {log_q[0], log_q[1], log_q[2], log_q[3], log_q[4]},
            {5'h04, 5'h10, 5'h08, 5'h0C, 5'h14});
        status_val = 8'h00;
        @(posedge PCLK); #1 rx_ready = 1'b1;
        @(posedge PCLK); #1 rx_ready = 1'b0;
        wait_cyc(6);
        chk("reconfig_drained", 32'(exp_q.size()), 32'd0);

        // ---- reset in the middle of a transfer ----
        wait_phase(5'h00, 2, "access_before_reset");
        aresetn = 1'b0;
        #1;
        chk("reset_async", {m_psel, m_penable, cfg_done}, 32'd0);
        log_q.delete();
        push(1'b1, 5'h08, 8'hA5);
        push(1'b1, 5'h0C, 8'h0B);
        push(1'b1, 5'h14, 8'h05);
        @(posedge PCLK); #1 aresetn = 1'b1;
        wait_cfg_done("restart_done");
        chk("restart_sequence", {log_q[0], log_q[1], log_q[2]}, {5'h08, 5'h0C, 5'h14});
        wait_cyc(6);
        chk("restart_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
